// File: rtl/bin_maxpool2d_if.sv
// Level-handshake bundle between bin_maxpool2d and its neighbours: C input maps in, C pooled maps
// out, plus the ready/busy flags.
interface bin_maxpool2d_if #(
    parameter int unsigned C            = 8,
    parameter int unsigned IMG_IN_SIZE  = 28,
    parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2
);
    logic                                             data_in_ready;
    logic [C-1:0][IMG_IN_SIZE*IMG_IN_SIZE-1:0]        img_in;
    logic [C-1:0][IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]      img_out;
    logic                                             data_out_ready;
    logic                                             busy;

    modport master (
        output data_in_ready, img_in,
        input  img_out, data_out_ready, busy
    );

    modport slave (
        input  data_in_ready, img_in,
        output img_out, data_out_ready, busy
    );
endinterface

// File: rtl/bin_maxpool2d.sv
// Binary 2x2/stride-2 max-pool, one channel per clock, behind the Conv2d level handshake.
// Define BNN_POOL_MAJORITY_EN to replace the 4-input OR with a 2-of-4 majority vote.
module bin_maxpool2d #(
    parameter int unsigned C            = 8,
    parameter int unsigned IMG_IN_SIZE  = 28,
    parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
    input  logic            clk,
    input  logic            rst,
    bin_maxpool2d_if.slave  bus
);
    localparam int unsigned NI = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int unsigned NO = IMG_OUT_SIZE * IMG_OUT_SIZE;
    localparam int unsigned CW = $clog2(C + 1);
    localparam int unsigned IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [C-1:0][NO-1:0] img_q, img_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic [IW-1:0]        ch_idx;
    logic [NO-1:0]        pooled;

    // Odd IMG_IN_SIZE: the trailing row/column never falls inside a window and is dropped.
    function automatic logic [NO-1:0] pool(input logic [NI-1:0] m);
        logic a, b, c, d;
        pool = '0;
        for (int r = 0; r < IMG_OUT_SIZE; r++) begin
            for (int k = 0; k < IMG_OUT_SIZE; k++) begin
                a = m[(2*r)*IMG_IN_SIZE + 2*k];
                b = m[(2*r)*IMG_IN_SIZE + 2*k + 1];
                c = m[(2*r+1)*IMG_IN_SIZE + 2*k];
                d = m[(2*r+1)*IMG_IN_SIZE + 2*k + 1];
`ifdef BNN_POOL_MAJORITY_EN
                pool[r*IMG_OUT_SIZE + k] = (a & b) | (a & c) | (a & d) | (b & c) | (b & d) | (c & d);
`else
                pool[r*IMG_OUT_SIZE + k] = a | b | c | d;
`endif
            end
        end
    endfunction

    // ch_q is 0 in IDLE, so one pooling datapath serves both IDLE and RUN writes.
    assign ch_idx = ch_q[IW-1:0];
    assign pooled = pool(bus.img_in[ch_idx]);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        img_d   = img_q;
        if (!bus.data_in_ready) begin
            // Abort/teardown: any drop discards whatever has been pooled so far.
            state_d = StIdle;
            ch_d    = '0;
            img_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StRun: begin
                    img_d[ch_idx] = pooled;
                    ch_d          = ch_q + CW'(1);
                    state_d       = (ch_q == CW'(C - 1)) ? StDone : StRun;
                end
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
        done_d = (state_d == StDone);
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ch_q    <= '0;
            img_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            img_q   <= img_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.img_out        = img_q;
    assign bus.data_out_ready = done_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_bin_maxpool2d.sv
// Directed bench for bin_maxpool2d: table of hand-built maps with hand-derived pooled results,
// plus sequences for async reset, abort and DONE freeze.
module tb_bin_maxpool2d;
    localparam int unsigned C  = 8;
    localparam int unsigned S  = 28;
    localparam int unsigned O  = 14;
    localparam int unsigned NI = S * S;
    localparam int unsigned NO = O * O;

    typedef struct {
        logic [C-1:0][NI-1:0] img;
        logic [C-1:0][NO-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_maxpool2d_if #(.C(C), .IMG_IN_SIZE(S), .IMG_OUT_SIZE(O)) bus ();

    bin_maxpool2d #(.C(C), .IMG_IN_SIZE(S), .IMG_OUT_SIZE(O)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs [3];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [NO-1:0] act, input logic [NO-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        for (int i = 0; i < C; i++) check($sformatf("%s img_out[%0d] clear", tag, i),
                                          bus.img_out[i], '0);
        check({tag, " data_out_ready low"}, NO'(bus.data_out_ready), '0);
        check({tag, " busy low"}, NO'(bus.busy), '0);
    endtask

    function automatic void setpix(int k, int ch, int r, int c);
        vecs[k].img[ch][r*S + c] = 1'b1;
    endfunction

    function automatic void setout(int k, int ch, int r, int c);
        vecs[k].exp[ch][r*O + c] = 1'b1;
    endfunction

    // Full handshake: rise, C edges of progress, result check, drop, clear check.
    task automatic run_vec(input int k);
        bus.img_in        = vecs[k].img;
        bus.data_in_ready = 1'b1;
        for (int e = 1; e <= C; e++) begin
            tick();
            check($sformatf("v%0d busy edge %0d", k, e), NO'(bus.busy), NO'(e < C));
            check($sformatf("v%0d ready edge %0d", k, e), NO'(bus.data_out_ready), NO'(e == C));
        end
        for (int i = 0; i < C; i++)
            check($sformatf("v%0d img_out[%0d]", k, i), bus.img_out[i], vecs[k].exp[i]);
        bus.data_in_ready = 1'b0;
        tick();
        check_idle($sformatf("v%0d drop", k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            vecs[k].img = '0;
            vecs[k].exp = '0;
        end
        // v0: everything set -> everything set, in either pooling mode.
        vecs[0].img = '1;
        vecs[0].exp = '1;
        // v1: corner singles, checkerboard, window-origin grid, small shapes.
        setpix(1, 0, 0, 0);
        setpix(1, 1, 27, 27);
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++) begin
                if (((r + c) % 2) == 0) setpix(1, 2, r, c);
                if ((r % 2 == 0) && (c % 2 == 0)) setpix(1, 3, r, c);
            end
        setpix(1, 4, 1, 3);
        setpix(1, 5, 2, 4); setpix(1, 5, 2, 5); setpix(1, 5, 3, 4); setpix(1, 5, 3, 5);
        setpix(1, 6, 0, 0); setpix(1, 6, 1, 1);
        vecs[1].exp[2] = '1;
        setout(1, 5, 1, 2);
        setout(1, 6, 0, 0);
        // v2: last row pair filled on map7, single pixel on that row pair on map0.
        setpix(2, 0, 26, 1);
        for (int c = 0; c < S; c++) begin
            setpix(2, 7, 26, c);
            setpix(2, 7, 27, c);
        end
        for (int c = 0; c < O; c++) setout(2, 7, 13, c);
`ifndef BNN_POOL_MAJORITY_EN
        setout(1, 0, 0, 0);
        setout(1, 1, 13, 13);
        vecs[1].exp[3] = '1;
        setout(1, 4, 0, 1);
        setout(2, 0, 13, 0);
`endif

        // Reset state.
        rst               = 1'b1;
        bus.data_in_ready = 1'b0;
        bus.img_in        = '0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-RUN, then a clean run straight after release.
        bus.img_in        = vecs[0].img;
        bus.data_in_ready = 1'b1;
        for (int e = 0; e < 3; e++) tick();
        check("pre-reset busy", NO'(bus.busy), NO'(1));
        check("pre-reset img_out[2]", bus.img_out[2], '1);
        rst = 1'b1;
        #1;
        check_idle("async reset");
        #2;
        rst = 1'b0;
        for (int e = 1; e <= C; e++) begin
            tick();
            check($sformatf("post-reset ready edge %0d", e), NO'(bus.data_out_ready),
                  NO'(e == C));
        end
        bus.data_in_ready = 1'b0;
        tick();
        check_idle("post-reset drop");

        for (int k = 0; k < 3; k++) run_vec(k);

        // Abort after edge 4, then a full re-run.
        bus.img_in        = vecs[1].img;
        bus.data_in_ready = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        check("abort busy before drop", NO'(bus.busy), NO'(1));
        bus.data_in_ready = 1'b0;
        tick();
        check_idle("abort");
        run_vec(1);

        // DONE ignores img_in changes; the drop clears on the next edge.
        bus.img_in        = vecs[0].img;
        bus.data_in_ready = 1'b1;
        for (int e = 0; e < C; e++) tick();
        bus.img_in = vecs[1].img;
        tick();
        tick();
        check("done ready held", NO'(bus.data_out_ready), NO'(1));
        check("done busy low", NO'(bus.busy), NO'(0));
        for (int i = 0; i < C; i++)
            check($sformatf("done frozen img_out[%0d]", i), bus.img_out[i], vecs[0].exp[i]);
        bus.data_in_ready = 1'b0;
        #2;
        check("drop waits for edge", NO'(bus.data_out_ready), NO'(1));
        tick();
        check_idle("done drop");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
